// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low blank/off codes and hex glyphs.
// Segment order is {g,f,e,d,c,b,a}; a cleared bit lights that segment.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bundle: content/mask inputs from the game/menu logic and the scanned anode/cathode pins.
// The master drives content; the slave (scan driver) drives the pins and the frame_start pulse.
interface seg7_scan_driver_if;

  logic        enable;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  out;
  logic        frame_start;

  modport master (
    output enable, digits, blank, blink,
    input  an, out, frame_start
  );

  modport slave (
    input  enable, digits, blank, blink,
    output an, out, frame_start
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g..a} glyph decoder; zero latency, no flow control.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-seg scanner with frame-coherent capture, anode dead-time and frame-locked blink.
// Pins are registered one cycle behind the scan counters; free-running, no backpressure.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 131072,
  parameter int DEAD_CYCLES  = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_scan_driver_if.slave disp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] slotCnt;
  logic [1:0]    digIdx;
  logic [FW-1:0] frameCnt;
  logic          blinkOff;
  logic          running;
  logic [15:0]   shDigits;
  logic [3:0]    shBlank;
  logic [3:0]    shBlink;
  logic [3:0]    anReg;
  logic [6:0]    segReg;
  logic          fsReg;

  logic          slotTick;
  logic          frameEnd;
  logic          capture;
  logic          dark;
  logic [3:0]    curNib;
  logic [6:0]    segCode;
  logic [3:0]    anNext;
  logic [6:0]    segNext;

  assign slotTick = (slotCnt == CW'(REFRESH_DIV - 1));
  assign frameEnd = running && slotTick && (digIdx == 2'd3);
  // The very first edge out of reset opens frame 0 without advancing the slot counter.
  assign capture  = !running || frameEnd;

  assign curNib = shDigits[{digIdx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (curNib),
    .seg    (segCode)
  );

  always_comb begin
    dark = (slotCnt < CW'(DEAD_CYCLES)) || !disp.enable ||
           shBlank[digIdx] || (shBlink[digIdx] && blinkOff);
    anNext  = AN_OFF;
    segNext = SEG_BLANK;
    if (!dark) begin
      anNext  = ~(4'b0001 << digIdx);
      segNext = segCode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      slotCnt  <= '0;
      digIdx   <= 2'd0;
      frameCnt <= '0;
      blinkOff <= 1'b0;
      shDigits <= 16'h0000;
      shBlank  <= 4'h0;
      shBlink  <= 4'h0;
      anReg    <= AN_OFF;
      segReg   <= SEG_BLANK;
      fsReg    <= 1'b0;
    end else begin
      running <= 1'b1;
      if (running) begin
        slotCnt <= slotTick ? '0 : slotCnt + 1'b1;
        if (slotTick) begin
          digIdx <= digIdx + 2'd1;
        end
      end
      if (frameEnd) begin
        if (frameCnt == FW'(BLINK_FRAMES - 1)) begin
          frameCnt <= '0;
          blinkOff <= ~blinkOff;
        end else begin
          frameCnt <= frameCnt + 1'b1;
        end
      end
      if (capture) begin
        shDigits <= disp.digits;
        shBlank  <= disp.blank;
        shBlink  <= disp.blink;
      end
      fsReg  <= capture;
      anReg  <= anNext;
      segReg <= segNext;
    end
  end

  assign disp.an          = anReg;
  assign disp.out         = segReg;
  assign disp.frame_start = fsReg;

endmodule
